// File: rtl/mult_product_assembler.sv
// mult_product_assembler
//
// Sequences an external operand selector and two 8x8 unsigned multipliers to
// build a packed SIMD product. One partial product pair is consumed per RUN
// cycle, and the pair is shifted into place in a 64-bit accumulator.
//
//   sew 00 : four 8x8  lanes, 16-bit results, 2 steps
//   sew 01 : two 16x16 lanes, 32-bit results, 4 steps
//   sew 10 : one 32x32 lane,  64-bit result, 16 steps
//   sew 11 : illegal, completes at once with result 0 and illegal set
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   start        request a new multiply (sampled in IDLE only)
//   sew[1:0]     element width, latched on an accepted start
//   mult1_p      product from multiplier 1 (combinational from the counts)
//   mult2_p      product from multiplier 2 (combinational from the counts)
//   out_ready    consumer accepts the result
//   count_16bit  byte-select step for sew 00/01
//   count_32bit  byte-select step for sew 10: [1:0]=A byte, [3:2]=B byte
//   busy         high in RUN and DONE
//   out_valid    result available
//   result       assembled products
//   illegal      qualifies out_valid, set for sew 11
module mult_product_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  sew,
   input  logic [15:0] mult1_p,
   input  logic [15:0] mult2_p,
   input  logic        out_ready,
   output logic [1:0]  count_16bit,
   output logic [3:0]  count_32bit,
   output logic        busy,
   output logic        out_valid,
   output logic [63:0] result,
   output logic        illegal
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam logic [1:0] Sew8  = 2'b00;
   localparam logic [1:0] Sew16 = 2'b01;
   localparam logic [1:0] Sew32 = 2'b10;
   localparam logic [1:0] SewIl = 2'b11;

   state_e      state_q, state_d;
   logic [1:0]  sew_q, sew_d;
   logic [3:0]  step_q, step_d;
   logic [63:0] acc_q, acc_d;
   logic        illegal_q, illegal_d;

   // Byte offsets of the current partial product inside its lane.
   logic [2:0]  half_sum;
   logic [2:0]  full_sum;
   logic [5:0]  half_sh;
   logic [5:0]  full_sh;
   logic [31:0] lo_add;
   logic [31:0] hi_add;
   logic [63:0] full_add;
   logic        last_step;

   assign half_sum = {2'b00, step_q[0]} + {2'b00, step_q[1]};
   assign full_sum = {1'b0, step_q[1:0]} + {1'b0, step_q[3:2]};
   assign half_sh  = {half_sum, 3'b000};
   assign full_sh  = {full_sum, 3'b000};

   // The two 32-bit halves are summed separately so no carry crosses lanes.
   assign lo_add   = acc_q[31:0]  + ({16'd0, mult1_p} << half_sh);
   assign hi_add   = acc_q[63:32] + ({16'd0, mult2_p} << half_sh);
   assign full_add = acc_q + ({48'd0, mult1_p} << full_sh);

   always_comb begin
      last_step = 1'b0;
      case (sew_q)
         Sew8:    last_step = (step_q == 4'd1);
         Sew16:   last_step = (step_q == 4'd3);
         Sew32:   last_step = (step_q == 4'd15);
         default: last_step = 1'b1;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      sew_d     = sew_q;
      step_d    = step_q;
      acc_d     = acc_q;
      illegal_d = illegal_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sew_d  = sew;
               step_d = 4'd0;
               acc_d  = 64'd0;
               if (sew == SewIl) begin
                  illegal_d = 1'b1;
                  state_d   = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end

         StRun: begin
            case (sew_q)
               Sew8: begin
                  // Step k places lane k and lane k+2 directly.
                  if (step_q[0]) begin
                     acc_d[31:16] = mult1_p;
                     acc_d[63:48] = mult2_p;
                  end else begin
                     acc_d[15:0]  = mult1_p;
                     acc_d[47:32] = mult2_p;
                  end
               end
               Sew16:   acc_d = {hi_add, lo_add};
               Sew32:   acc_d = full_add;
               default: acc_d = acc_q;
            endcase
            step_d = step_q + 4'd1;
            if (last_step) begin
               state_d = StDone;
            end
         end

         StDone: begin
            if (out_ready) begin
               illegal_d = 1'b0;
               state_d   = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         sew_q     <= 2'b00;
         step_q    <= 4'd0;
         acc_q     <= 64'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sew_q     <= sew_d;
         step_q    <= step_d;
         acc_q     <= acc_d;
         illegal_q <= illegal_d;
      end
   end

   // Operand byte selects, only meaningful while stepping.
   always_comb begin
      count_16bit = 2'b00;
      count_32bit = 4'b0000;
      if (state_q == StRun) begin
         case (sew_q)
            Sew8:    count_16bit = {1'b0, step_q[0]};
            Sew16:   count_16bit = step_q[1:0];
            Sew32:   count_32bit = step_q;
            default: begin
               count_16bit = 2'b00;
               count_32bit = 4'b0000;
            end
         endcase
      end
   end

   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = acc_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_mult_product_assembler.sv
// Bench for mult_product_assembler: models the operand selector and two 8x8
// multipliers around the block, drives directed jobs and checks results
// through a scoreboard drained by an independent monitor.
module tb_mult_product_assembler;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  sew;
   logic [15:0] mult1_p;
   logic [15:0] mult2_p;
   logic        out_ready;
   logic [1:0]  count_16bit;
   logic [3:0]  count_32bit;
   logic        busy;
   logic        out_valid;
   logic [63:0] result;
   logic        illegal;

   // Operands held by the upstream stage while the block is busy.
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [1:0]  op_sew;

   typedef struct packed {
      logic [63:0] res;
      logic        ill;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mult_product_assembler dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .sew         (sew),
      .mult1_p     (mult1_p),
      .mult2_p     (mult2_p),
      .out_ready   (out_ready),
      .count_16bit (count_16bit),
      .count_32bit (count_32bit),
      .busy        (busy),
      .out_valid   (out_valid),
      .result      (result),
      .illegal     (illegal)
   );

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] r;
      case (idx)
         2'd0:    r = w[7:0];
         2'd1:    r = w[15:8];
         2'd2:    r = w[23:16];
         default: r = w[31:24];
      endcase
      return r;
   endfunction

   function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
      return {8'd0, x} * {8'd0, y};
   endfunction

   // Operand selector plus the two combinational multipliers.
   always_comb begin
      mult1_p = 16'd0;
      mult2_p = 16'd0;
      case (op_sew)
         2'b00: begin
            mult1_p = mul8(byte_of(op_a, count_16bit), byte_of(op_b, count_16bit));
            mult2_p = mul8(byte_of(op_a, count_16bit + 2'd2),
                           byte_of(op_b, count_16bit + 2'd2));
         end
         2'b01: begin
            mult1_p = mul8(byte_of(op_a, {1'b0, count_16bit[0]}),
                           byte_of(op_b, {1'b0, count_16bit[1]}));
            mult2_p = mul8(byte_of(op_a, {1'b1, count_16bit[0]}),
                           byte_of(op_b, {1'b1, count_16bit[1]}));
         end
         2'b10: begin
            mult1_p = mul8(byte_of(op_a, count_32bit[1:0]), byte_of(op_b, count_32bit[3:2]));
         end
         default: begin
            mult1_p = 16'd0;
            mult2_p = 16'd0;
         end
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted result is compared with the oldest expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_unexpected: got result %h with empty scoreboard", result);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_result", result, mon_e.res);
            check("sb_illegal", 64'(illegal), 64'(mon_e.ill));
         end
      end
   end

   task automatic run_job(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat, input int hold);
      int         edges;
      logic [3:0] step;
      exp_t       e;
      @(negedge clk);
      op_a      = a;
      op_b      = b;
      op_sew    = s;
      sew       = s;
      start     = 1'b1;
      out_ready = (hold == 0);
      e.res     = exp_res;
      e.ill     = (s == 2'b11);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      while (!out_valid && edges < 40) begin
         step = 4'(edges - 1);
         case (s)
            2'b00: check("count16_s8", 64'(count_16bit), 64'({1'b0, step[0]}));
            2'b01: check("count16_s16", 64'(count_16bit), 64'(step[1:0]));
            default: begin
               check("count32_s32", 64'(count_32bit), 64'(step));
               check("count16_s32", 64'(count_16bit), 64'd0);
            end
         endcase
         @(posedge clk);
         #1;
         edges++;
      end
      check("latency", 64'(edges), 64'(lat));
      check("busy_done", 64'(busy), 64'd1);
      if (s == 2'b11) begin
         check("ill_count16", 64'(count_16bit), 64'd0);
         check("ill_count32", 64'(count_32bit), 64'd0);
      end
      for (int h = 0; h < hold; h++) begin
         start = 1'b1;
         sew   = 2'b00;
         @(posedge clk);
         #1;
         start = 1'b0;
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_result", result, exp_res);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_illegal", 64'(illegal), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("result_held", result, exp_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      sew       = 2'b00;
      out_ready = 1'b0;
      op_a      = 32'd0;
      op_b      = 32'd0;
      op_sew    = 2'b00;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_counts", 64'({count_32bit, count_16bit}), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run_job(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 17, 0);
      run_job(2'b01, 32'h0003_FFFF, 32'h0005_FFFF, 64'h0000_000F_FFFE_0001, 5, 0);
      run_job(2'b00, 32'h0403_0201, 32'h0807_0605, 64'h0020_0015_000C_0005, 3, 0);
      run_job(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0, 1, 0);
      run_job(2'b01, 32'h00FF_0100, 32'h0002_0100, 64'h0000_01FE_0001_0000, 5, 0);
      // Back-pressure with start pulses that must be ignored.
      run_job(2'b00, 32'hFF10_0A02, 32'hFF20_0B03, 64'hFE01_0200_006E_0006, 3, 3);

      // Asynchronous reset in the middle of a 32-bit job.
      @(negedge clk);
      op_a   = 32'hFFFF_FFFF;
      op_b   = 32'hFFFF_FFFF;
      op_sew = 2'b10;
      sew    = 2'b10;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 20 && count_32bit != 4'd7; i++) begin
         @(posedge clk);
         #1;
      end
      check("reached_step7", 64'(count_32bit), 64'd7);
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_illegal", 64'(illegal), 64'd0);
      check("arst_result", result, 64'd0);
      check("arst_counts", 64'({count_32bit, count_16bit}), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_job(2'b00, 32'h0403_0201, 32'h0807_0605, 64'h0020_0015_000C_0005, 3, 0);

      repeat (2) @(negedge clk);
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
